fft8_seq_ctrl: RTL and testbench
================================

Name: fft8_seq_ctrl

Overview:
Sequencer for the 8-point radix-2 DIT FFT datapath.
- Accepts 8 input samples over a valid/ready handshake and writes them into the sample register bank in bit-reversed order.
- Issues 3 stages × 4 butterflies with operand addresses and twiddle indices, waiting for the butterfly pipeline to drain between stages.
- Streams the 8 results out in natural order.
- Controls only: the reg_n sample bank, butterfly unit and twiddle ROM live outside this block.

Parameters:
N_POINTS, 8, transform size; this revision supports 8 only (3 stages, 3-bit addresses).
BF_LAT, 2, butterfly pipeline latency in cycles from bf_en to result valid; legal range 1..7.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-low reset.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample.
load_en  out  1  write enable, sample bank port (= in_valid & in_ready).
load_addr  out  3  bank write address for the current input sample (bit-reversed count).
bf_en  out  1  butterfly issue strobe.
stage  out  2  current stage, 0..2.
addr_a  out  3  butterfly top operand address.
addr_b  out  3  butterfly bottom operand address.
twiddle_idx  out  2  twiddle ROM index k (W8^k).
wb_en  out  1  writeback enable (bf_en delayed BF_LAT cycles).
wb_addr_a  out  3  addr_a delayed BF_LAT cycles.
wb_addr_b  out  3  addr_b delayed BF_LAT cycles.
out_valid  out  1  output sample valid.
out_ready  in  1  downstream accepts.
rd_addr  out  3  bank read address for output, natural order.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse on the last accepted output beat.

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE; all counters 0; in_ready, load_en, bf_en, wb_en, out_valid, busy, done = 0; all address and index outputs = 0; delay pipe flushed. Reset mid-operation aborts with no further wb_en.
- States: IDLE -> LOAD -> ISSUE -> DRAIN -> (ISSUE for next stage | UNLOAD) -> IDLE.
- IDLE: in_ready=1. The first in_valid beat is accepted and also enters LOAD (load_cnt becomes 1).
- LOAD: in_ready=1.
  - Each accepted beat: load_en=1, load_addr=bitrev3(load_cnt), load_cnt++.
  - After the 8th accepted beat go to ISSUE with stage=0, bf_idx=0; in_ready drops the following cycle.
  - in_valid low only stalls; no timeout.
- ISSUE: bf_en=1 for exactly 4 consecutive cycles, b=0..3.
  - half = 1<<stage.
  - addr_a = ((b>>stage)<<(stage+1)) | (b & (half-1)).
  - addr_b = addr_a + half.
  - twiddle_idx = (b & (half-1)) << (2-stage).
  - After b=3 go to DRAIN.
- DRAIN: bf_en=0 for BF_LAT cycles, so the last writeback lands before the next stage reads.
  - stage<2: increment stage and return to ISSUE.
  - stage=2: go to UNLOAD.
- wb_en, wb_addr_a and wb_addr_b are a BF_LAT-deep shift of bf_en, addr_a and addr_b; that pipe runs in every state.
- Compute cycles from the first bf_en to the last wb_en: 3×(4+BF_LAT) − BF_LAT + BF_LAT = 3×(4+BF_LAT).
- UNLOAD: out_valid=1, rd_addr=out_cnt (0..7).
  - Advance only on out_valid & out_ready.
  - Beat 7 accepted: done=1 that cycle, next state IDLE, out_valid=0 next cycle.
  - out_ready low holds rd_addr stable.
- Input is never accepted outside IDLE/LOAD. in_valid during compute or unload is ignored and held off by in_ready=0.
- Back-to-back frames: IDLE is occupied for 1 cycle minimum after done.

Optional Feature:
Macro FFT8_SEQ_CTRL_INV_EN.
- Defined:
  - Adds input port `inv` (1 bit), sampled on the first accepted input beat of a frame and held for that frame.
  - Adds output port `twiddle_conj` (1 bit), equal to the latched inv while bf_en=1, 0 otherwise. It selects conjugate twiddles for the IFFT.
  - When inv is latched, wb_en/out timing is unchanged.
- Undefined: neither port exists; forward-FFT behaviour only.

Test Plan:
1. Reset: hold rst=0 4 cycles with in_valid=1 -> in_ready, load_en, bf_en, wb_en, out_valid, busy, done all 0; release -> in_ready=1 next cycle.
2. Load order: 8 beats back-to-back -> load_addr sequence 0,4,2,6,1,5,3,7; in_ready=0 from the cycle after beat 8.
3. Compute sequence, BF_LAT=2:
   - stage0 (a,b) = (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0.
   - stage1 = (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
   - stage2 = (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
   - 2 idle cycles between stages; wb_en trails bf_en by exactly 2 cycles; 12 bf_en pulses total.
4. Unload backpressure: out_ready toggling 1,0,0,1,... -> rd_addr 0..7, held on stall cycles; done pulses once on beat 7; then state=IDLE and busy=0.
5. Reset mid-stage1: rst=0 on the 2nd bf_en of stage1 -> next cycle all outputs 0, no wb_en afterwards; a new frame then loads normally starting at load_addr 0.
6. (FFT8_SEQ_CTRL_INV_EN) frame with inv=1 then frame with inv=0 -> twiddle_conj=1 on all 12 bf_en cycles of frame 1, 0 throughout frame 2.

Source files
------------

// File: rtl/fft8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fft8_seq_ctrl
// Sequencer for an 8-point radix-2 decimation-in-time FFT datapath.
//
// Function
//   1. Accepts 8 input samples over a valid/ready handshake. Each sample is
//      written into the external sample bank at the bit-reversed position of
//      its arrival count.
//   2. Issues 3 stages of 4 butterflies each, with operand addresses and a
//      twiddle index. Between stages it waits BF_LAT cycles so that the
//      butterfly pipeline drains before the next stage reads its operands.
//   3. Streams the 8 results out in natural order.
//   The sample bank, butterfly unit and twiddle ROM are outside this block.
//
// Parameters
//   N_POINTS : transform size. Only 8 is supported (3 stages, 3-bit
//              addresses).
//   BF_LAT   : butterfly latency in cycles, from bf_en to result valid.
//              Legal range is 1..7.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 synchronous reset, active low
//   in_valid/in_ready   input sample handshake
//   load_en, load_addr  sample bank write strobe and bit-reversed address
//   bf_en, stage        butterfly issue strobe and current stage (0..2)
//   addr_a, addr_b      butterfly operand addresses
//   twiddle_idx         twiddle ROM index k, selecting W8^k
//   wb_en, wb_addr_a/b  issue strobe and operand addresses, delayed BF_LAT
//                       cycles, used to write the butterfly results back
//   out_valid/out_ready output handshake
//   rd_addr             bank read address for the output, natural order
//   busy                high in every state except IDLE
//   done                one-cycle pulse on the last accepted output beat
//
// Optional feature (macro FFT8_SEQ_CTRL_INV_EN)
//   Adds the input `inv`. It is sampled on the first accepted input beat of a
//   frame and held for that frame.
//   Adds the output `twiddle_conj`. It equals the held inv while bf_en is high
//   and is 0 otherwise; it selects conjugate twiddles for an inverse FFT.
//   Without the macro, neither port exists and the block sequences a forward
//   FFT only.
// -----------------------------------------------------------------------------
module fft8_seq_ctrl #(
    parameter int N_POINTS = 8,
    parameter int BF_LAT   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       load_en,
    output logic [2:0] load_addr,
    output logic       bf_en,
    output logic [1:0] stage,
    output logic [2:0] addr_a,
    output logic [2:0] addr_b,
    output logic [1:0] twiddle_idx,
    output logic       wb_en,
    output logic [2:0] wb_addr_a,
    output logic [2:0] wb_addr_b,
`ifdef FFT8_SEQ_CTRL_INV_EN
    input  logic       inv,
    output logic       twiddle_conj,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] rd_addr,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ISSUE  = 3'd2,
        DRAIN  = 3'd3,
        UNLOAD = 3'd4
    } state_t;

    localparam logic [2:0] LAST_SAMPLE = 3'(N_POINTS - 1);
    localparam logic [2:0] DRAIN_LAST  = 3'(BF_LAT - 1);
    localparam logic [1:0] LAST_STAGE  = 2'd2;
    localparam logic [1:0] LAST_BF     = 2'd3;

    // Bit reversal of a 3-bit sample index.
    function automatic logic [2:0] bitrev3(input logic [2:0] idx);
        bitrev3 = {idx[0], idx[1], idx[2]};
    endfunction

    // Span between the two operands of a butterfly: 1 << stage.
    function automatic logic [2:0] half_of(input logic [1:0] stg);
        case (stg)
            2'd0:    half_of = 3'd1;
            2'd1:    half_of = 3'd2;
            2'd2:    half_of = 3'd4;
            default: half_of = 3'd0;
        endcase
    endfunction

    // Top operand address: ((b >> stg) << (stg + 1)) | (b & (half - 1)).
    function automatic logic [2:0] top_addr(input logic [1:0] stg, input logic [1:0] b);
        case (stg)
            2'd0:    top_addr = {b, 1'b0};
            2'd1:    top_addr = {b[1], 1'b0, b[0]};
            2'd2:    top_addr = {1'b0, b};
            default: top_addr = 3'd0;
        endcase
    endfunction

    // Twiddle index: (b & (half - 1)) << (2 - stg).
    function automatic logic [1:0] tw_index(input logic [1:0] stg, input logic [1:0] b);
        case (stg)
            2'd0:    tw_index = 2'd0;
            2'd1:    tw_index = {b[0], 1'b0};
            2'd2:    tw_index = b;
            default: tw_index = 2'd0;
        endcase
    endfunction

    state_t     state_r, next_state_s;
    logic [2:0] load_cnt_r, next_load_cnt_s;
    logic [1:0] stage_r, next_stage_s;
    logic [1:0] bf_idx_r, next_bf_idx_s;
    logic [2:0] drain_cnt_r, next_drain_cnt_s;
    logic [2:0] out_cnt_r, next_out_cnt_s;

    logic       in_ready_r;
    logic       bf_en_r;
    logic [2:0] addr_a_r;
    logic [2:0] addr_b_r;
    logic [1:0] tw_r;
    logic       out_valid_r;
    logic [2:0] rd_addr_r;
    logic       busy_r;

    logic       load_en_s;
    logic       out_fire_s;
    logic       done_s;
    logic       issue_next_s;

    // Writeback delay line. Index 0 is the newest entry.
    logic       wb_en_pipe_r [BF_LAT];
    logic [2:0] wb_a_pipe_r  [BF_LAT];
    logic [2:0] wb_b_pipe_r  [BF_LAT];

`ifdef FFT8_SEQ_CTRL_INV_EN
    logic inv_r, next_inv_s;
    logic conj_r;
`endif

    // Decode the handshakes, then compute the next state and next counter values.
    always_comb begin
        next_state_s     = state_r;
        next_load_cnt_s  = load_cnt_r;
        next_stage_s     = stage_r;
        next_bf_idx_s    = bf_idx_r;
        next_drain_cnt_s = drain_cnt_r;
        next_out_cnt_s   = out_cnt_r;
        load_en_s        = in_valid & in_ready_r;
        out_fire_s       = out_valid_r & out_ready;
        done_s           = 1'b0;

        case (state_r)
            IDLE: begin
                // The first beat is written here; load_cnt is 0 in IDLE.
                if (load_en_s) begin
                    next_load_cnt_s = load_cnt_r + 3'd1;
                    next_state_s    = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (load_en_s) begin
                    // load_cnt wraps back to 0 after the last sample.
                    next_load_cnt_s = load_cnt_r + 3'd1;
                    if (load_cnt_r == LAST_SAMPLE) begin
                        next_state_s  = ISSUE;
                        next_stage_s  = 2'd0;
                        next_bf_idx_s = 2'd0;
                    end else begin
                        next_state_s = LOAD;
                    end
                end else begin
                    next_state_s = LOAD;
                end
            end
            ISSUE: begin
                next_bf_idx_s = bf_idx_r + 2'd1;
                if (bf_idx_r == LAST_BF) begin
                    next_state_s     = DRAIN;
                    next_drain_cnt_s = 3'd0;
                end else begin
                    next_state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    if (stage_r == LAST_STAGE) begin
                        next_state_s   = UNLOAD;
                        next_out_cnt_s = 3'd0;
                    end else begin
                        next_state_s  = ISSUE;
                        next_stage_s  = stage_r + 2'd1;
                        next_bf_idx_s = 2'd0;
                    end
                end else begin
                    next_drain_cnt_s = drain_cnt_r + 3'd1;
                end
            end
            UNLOAD: begin
                if (out_fire_s) begin
                    if (out_cnt_r == LAST_SAMPLE) begin
                        done_s         = 1'b1;
                        next_out_cnt_s = 3'd0;
                        next_state_s   = IDLE;
                    end else begin
                        next_out_cnt_s = out_cnt_r + 3'd1;
                    end
                end else begin
                    next_out_cnt_s = out_cnt_r;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase

        issue_next_s = (next_state_s == ISSUE);
    end

`ifdef FFT8_SEQ_CTRL_INV_EN
    // Capture inv on the first accepted beat of a frame.
    always_comb begin
        next_inv_s = inv_r;
        if ((state_r == IDLE) && load_en_s) begin
            next_inv_s = inv;
        end else begin
            next_inv_s = inv_r;
        end
    end
`endif

    // State, counters and output registers. Each output is computed from the
    // next-state values, so it lines up with the state it describes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            load_cnt_r  <= 3'd0;
            stage_r     <= 2'd0;
            bf_idx_r    <= 2'd0;
            drain_cnt_r <= 3'd0;
            out_cnt_r   <= 3'd0;
            in_ready_r  <= 1'b0;
            bf_en_r     <= 1'b0;
            addr_a_r    <= 3'd0;
            addr_b_r    <= 3'd0;
            tw_r        <= 2'd0;
            out_valid_r <= 1'b0;
            rd_addr_r   <= 3'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            load_cnt_r  <= next_load_cnt_s;
            stage_r     <= next_stage_s;
            bf_idx_r    <= next_bf_idx_s;
            drain_cnt_r <= next_drain_cnt_s;
            out_cnt_r   <= next_out_cnt_s;
            in_ready_r  <= (next_state_s == IDLE) || (next_state_s == LOAD);
            bf_en_r     <= issue_next_s;
            addr_a_r    <= issue_next_s ? top_addr(next_stage_s, next_bf_idx_s) : 3'd0;
            addr_b_r    <= issue_next_s ? (top_addr(next_stage_s, next_bf_idx_s)
                                           + half_of(next_stage_s)) : 3'd0;
            tw_r        <= issue_next_s ? tw_index(next_stage_s, next_bf_idx_s) : 2'd0;
            out_valid_r <= (next_state_s == UNLOAD);
            rd_addr_r   <= (next_state_s == UNLOAD) ? next_out_cnt_s : 3'd0;
            busy_r      <= (next_state_s != IDLE);
        end
    end

    // Writeback delay line. It shifts in every state, and reset clears it so
    // that no writeback fires after an abort.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BF_LAT; i++) begin
                wb_en_pipe_r[i] <= 1'b0;
                wb_a_pipe_r[i]  <= 3'd0;
                wb_b_pipe_r[i]  <= 3'd0;
            end
        end else begin
            wb_en_pipe_r[0] <= bf_en_r;
            wb_a_pipe_r[0]  <= addr_a_r;
            wb_b_pipe_r[0]  <= addr_b_r;
            for (int i = 1; i < BF_LAT; i++) begin
                wb_en_pipe_r[i] <= wb_en_pipe_r[i-1];
                wb_a_pipe_r[i]  <= wb_a_pipe_r[i-1];
                wb_b_pipe_r[i]  <= wb_b_pipe_r[i-1];
            end
        end
    end

`ifdef FFT8_SEQ_CTRL_INV_EN
    // Hold inv for the frame; present it as twiddle_conj only while issuing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inv_r  <= 1'b0;
            conj_r <= 1'b0;
        end else begin
            inv_r  <= next_inv_s;
            conj_r <= issue_next_s & next_inv_s;
        end
    end

    assign twiddle_conj = conj_r;
`endif

    assign in_ready    = in_ready_r;
    assign load_en     = load_en_s;
    assign load_addr   = bitrev3(load_cnt_r);
    assign bf_en       = bf_en_r;
    assign stage       = stage_r;
    assign addr_a      = addr_a_r;
    assign addr_b      = addr_b_r;
    assign twiddle_idx = tw_r;
    assign wb_en       = wb_en_pipe_r[BF_LAT-1];
    assign wb_addr_a   = wb_a_pipe_r[BF_LAT-1];
    assign wb_addr_b   = wb_b_pipe_r[BF_LAT-1];
    assign out_valid   = out_valid_r;
    assign rd_addr     = rd_addr_r;
    assign busy        = busy_r;
    assign done        = done_s;

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft8_seq_ctrl
// Directed, table-driven bench for fft8_seq_ctrl with BF_LAT = 2.
// Inputs are driven 1 time unit after the rising edge.
// Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fft8_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       load_en;
    logic [2:0] load_addr;
    logic       bf_en;
    logic [1:0] stage;
    logic [2:0] addr_a;
    logic [2:0] addr_b;
    logic [1:0] twiddle_idx;
    logic       wb_en;
    logic [2:0] wb_addr_a;
    logic [2:0] wb_addr_b;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] rd_addr;
    logic       busy;
    logic       done;
`ifdef FFT8_SEQ_CTRL_INV_EN
    logic       inv;
    logic       twiddle_conj;
    bit         frame_inv;
`endif

    int total = 0;
    int bad   = 0;

    // One row of the load-phase table.
    typedef struct {
        logic       valid;
        logic       exp_load_en;
        logic [2:0] exp_addr;
    } load_vec_t;

    // One butterfly issue.
    typedef struct {
        logic [1:0] stg;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
    } bf_vec_t;

    load_vec_t  load_tbl [9];
    bf_vec_t    bf_tbl   [12];
    logic [2:0] br_tbl   [8];

    fft8_seq_ctrl #(.N_POINTS(8), .BF_LAT(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .bf_en       (bf_en),
        .stage       (stage),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .twiddle_idx (twiddle_idx),
        .wb_en       (wb_en),
        .wb_addr_a   (wb_addr_a),
        .wb_addr_b   (wb_addr_b),
`ifdef FFT8_SEQ_CTRL_INV_EN
        .inv         (inv),
        .twiddle_conj(twiddle_conj),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rd_addr     (rd_addr),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Eight back-to-back input beats, checking the bit-reversed write addresses.
    task automatic load_beats();
        for (int i = 0; i < 8; i++) begin
            next_cyc();
            in_valid = 1'b1;
`ifdef FFT8_SEQ_CTRL_INV_EN
            // Change inv after the first beat to show that the sampled value is held.
            inv = (i == 0) ? frame_inv : ~frame_inv;
`endif
            @(negedge clk);
            chk("load_in_ready", in_ready, 1);
            chk("load_en", load_en, 1);
            chk("load_addr", load_addr, br_tbl[i]);
        end
    endtask

    // Follow n cycles of compute, starting with the first bf_en cycle.
    // in_valid is held high the whole time to show that input is held off.
    task automatic compute_check(input int n);
        int bf_cnt;
        bit bf_exp;
        bit wb_exp;
        int idx;
        bf_cnt = 0;
        for (int c = 0; c < n; c++) begin
            next_cyc();
            in_valid = 1'b1;
            @(negedge clk);
            bf_exp = (c % 6) < 4;
            wb_exp = (c >= 2) && (((c - 2) % 6) < 4);
            chk("cmp_bf_en", bf_en, bf_exp);
            chk("cmp_wb_en", wb_en, wb_exp);
            chk("cmp_in_ready", in_ready, 0);
            chk("cmp_load_en", load_en, 0);
            chk("cmp_busy", busy, 1);
            chk("cmp_out_valid", out_valid, 0);
            if (bf_exp) begin
                bf_cnt++;
                idx = (c / 6) * 4 + (c % 6);
                chk("cmp_stage", stage, bf_tbl[idx].stg);
                chk("cmp_addr_a", addr_a, bf_tbl[idx].a);
                chk("cmp_addr_b", addr_b, bf_tbl[idx].b);
                chk("cmp_twiddle", twiddle_idx, bf_tbl[idx].tw);
            end
            if (wb_exp) begin
                idx = ((c - 2) / 6) * 4 + ((c - 2) % 6);
                chk("cmp_wb_addr_a", wb_addr_a, bf_tbl[idx].a);
                chk("cmp_wb_addr_b", wb_addr_b, bf_tbl[idx].b);
            end
`ifdef FFT8_SEQ_CTRL_INV_EN
            chk("cmp_twiddle_conj", twiddle_conj, bf_exp ? frame_inv : 1'b0);
`endif
        end
        if (n == 18) begin
            chk("bf_pulse_count", bf_cnt, 12);
        end
    endtask

    // Drain the 8 results. mode 0 drives out_ready as 1,0,0,1,0,0,...;
    // mode 1 holds out_ready high.
    task automatic unload_check(input int mode);
        int exp_cnt;
        int done_seen;
        int k;
        exp_cnt   = 0;
        done_seen = 0;
        k         = 0;
        in_valid  = 1'b0;
        while ((exp_cnt < 8) && (k < 40)) begin
            next_cyc();
            out_ready = (mode == 1) ? 1'b1 : ((k % 3) == 0);
            @(negedge clk);
            chk("unl_out_valid", out_valid, 1);
            chk("unl_rd_addr", rd_addr, exp_cnt);
            chk("unl_done", done, (out_ready && (exp_cnt == 7)) ? 1 : 0);
            chk("unl_in_ready", in_ready, 0);
            if (done) begin
                done_seen++;
            end
            if (out_ready) begin
                exp_cnt++;
            end
            k++;
        end
        chk("unl_beats", exp_cnt, 8);
        next_cyc();
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_out_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        chk("post_in_ready", in_ready, 1);
        chk("done_pulses", done_seen, 1);
    endtask

    initial begin
        // Load phase: back-to-back beats, with one stall cycle after beat 3.
        load_tbl[0] = '{1'b1, 1'b1, 3'd0};
        load_tbl[1] = '{1'b1, 1'b1, 3'd4};
        load_tbl[2] = '{1'b1, 1'b1, 3'd2};
        load_tbl[3] = '{1'b0, 1'b0, 3'd6};
        load_tbl[4] = '{1'b1, 1'b1, 3'd6};
        load_tbl[5] = '{1'b1, 1'b1, 3'd1};
        load_tbl[6] = '{1'b1, 1'b1, 3'd5};
        load_tbl[7] = '{1'b1, 1'b1, 3'd3};
        load_tbl[8] = '{1'b1, 1'b1, 3'd7};

        bf_tbl[0]  = '{2'd0, 3'd0, 3'd1, 2'd0};
        bf_tbl[1]  = '{2'd0, 3'd2, 3'd3, 2'd0};
        bf_tbl[2]  = '{2'd0, 3'd4, 3'd5, 2'd0};
        bf_tbl[3]  = '{2'd0, 3'd6, 3'd7, 2'd0};
        bf_tbl[4]  = '{2'd1, 3'd0, 3'd2, 2'd0};
        bf_tbl[5]  = '{2'd1, 3'd1, 3'd3, 2'd2};
        bf_tbl[6]  = '{2'd1, 3'd4, 3'd6, 2'd0};
        bf_tbl[7]  = '{2'd1, 3'd5, 3'd7, 2'd2};
        bf_tbl[8]  = '{2'd2, 3'd0, 3'd4, 2'd0};
        bf_tbl[9]  = '{2'd2, 3'd1, 3'd5, 2'd1};
        bf_tbl[10] = '{2'd2, 3'd2, 3'd6, 2'd2};
        bf_tbl[11] = '{2'd2, 3'd3, 3'd7, 2'd3};

        br_tbl[0] = 3'd0; br_tbl[1] = 3'd4; br_tbl[2] = 3'd2; br_tbl[3] = 3'd6;
        br_tbl[4] = 3'd1; br_tbl[5] = 3'd5; br_tbl[6] = 3'd3; br_tbl[7] = 3'd7;

        rst       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
`ifdef FFT8_SEQ_CTRL_INV_EN
        inv       = 1'b0;
        frame_inv = 1'b0;
`endif

        // Hold reset for 4 cycles with in_valid high.
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            @(negedge clk);
            chk("rst_ctrl_outs", {in_ready, load_en, bf_en, wb_en, out_valid, busy, done}, 0);
        end
        next_cyc();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_release_same_cycle", in_ready, 0);
        next_cyc();
        @(negedge clk);
        chk("rst_release_in_ready", in_ready, 1);
        chk("rst_release_busy", busy, 0);

        // Frame 1: table-driven load, then the full compute sequence, then
        // unload under backpressure.
        for (int i = 0; i < 9; i++) begin
            next_cyc();
            in_valid = load_tbl[i].valid;
            @(negedge clk);
            chk("tbl_in_ready", in_ready, 1);
            chk("tbl_load_en", load_en, load_tbl[i].exp_load_en);
            chk("tbl_load_addr", load_addr, load_tbl[i].exp_addr);
        end
        compute_check(18);
        unload_check(0);

        // Frame 2: assert reset on the 2nd stage-1 issue cycle.
        load_beats();
        compute_check(8);
        rst = 1'b0;
        in_valid = 1'b0;
        next_cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ctrl_outs", {in_ready, load_en, bf_en, wb_en, out_valid, busy, done}, 0);
        chk("abort_addr_outs", {stage, addr_a, addr_b, twiddle_idx, wb_addr_a, wb_addr_b,
                                rd_addr, load_addr}, 0);
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            @(negedge clk);
            chk("abort_no_wb", wb_en, 0);
        end
        chk("abort_idle_ready", in_ready, 1);

        // Frame 3: a full frame after the abort, with out_ready held high.
        load_beats();
        compute_check(18);
        unload_check(1);

`ifdef FFT8_SEQ_CTRL_INV_EN
        // An inverse frame followed by a forward frame.
        frame_inv = 1'b1;
        load_beats();
        compute_check(18);
        unload_check(1);
        frame_inv = 1'b0;
        load_beats();
        compute_check(18);
        unload_check(1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
